// File: rtl/voice_allocator_if.sv
`default_nettype none
// ============================================================================
//  Module      : voice_allocator_if
//  Description : Bundle between the key-decode side and the voice allocator.
//                master -> key decode / host: drives the held-note mask and
//                          observes voice state.
//                slave  -> voice allocator: samples the mask and drives the
//                          voice state, event pulses and busy flag.
//  Signals     : note[7:0]        held-note mask, bit i = note i held
//                voice_on[3:0]    bit v = voice v sounding
//                voice_note[11:0] note index of voice v in [3v+2:3v]
//                voice_trig[3:0]  one-cycle envelope restart per voice
//                steal            one-cycle pulse, busy voice reassigned
//                drop             one-cycle pulse, press discarded
//                busy             a press or release event is pending
//  Revision    : 1.0  initial release
// ============================================================================
interface voice_allocator_if;
    logic [7:0]  note;
    logic [3:0]  voice_on;
    logic [11:0] voice_note;
    logic [3:0]  voice_trig;
    logic        steal;
    logic        drop;
    logic        busy;

    modport master (
        output note,
        input  voice_on, voice_note, voice_trig, steal, drop, busy
    );

    modport slave (
        input  note,
        output voice_on, voice_note, voice_trig, steal, drop, busy
    );
endinterface
`default_nettype wire

// File: rtl/voice_allocator.sv
`default_nettype none
// ============================================================================
//  Module      : voice_allocator
//  Description : Four-voice note allocator for an eight-key keyboard. Key
//                edges are queued as pending press/release bits and serviced
//                one per cycle: releases first, then presses, lowest note
//                index first. A press takes the lowest free voice; with all
//                voices busy it either steals the least-recently-allocated
//                voice (STEAL_EN=1) or is dropped (STEAL_EN=0).
//  Ports       : clk    system clock, rising edge
//                rst_n  asynchronous active-low reset
//                bus    voice_allocator_if.slave (note in; voice_on,
//                       voice_note, voice_trig, steal, drop, busy out)
//  Parameters  : STEAL_EN  1 = steal oldest voice, 0 = drop press
//  Revision    : 1.0  initial release
// ============================================================================
module voice_allocator #(
    parameter bit STEAL_EN = 1'b1
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    voice_allocator_if.slave  bus
);

    // Action taken at the most recent edge.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REL   = 2'd1,
        ALLOC = 2'd2,
        STEAL = 2'd3
    } state_t;

    // Voice v starts with rank v so the rank set is a permutation from reset.
    localparam logic [3:0][1:0] RANK_RST = {2'd3, 2'd2, 2'd1, 2'd0};

    state_t           state_q,      state_d;
    logic [7:0]       note_q,       note_d;
    logic [7:0]       pend_press_q, pend_press_d;
    logic [7:0]       pend_rel_q,   pend_rel_d;
    logic [3:0]       voice_on_q,   voice_on_d;
    logic [3:0][2:0]  voice_note_q, voice_note_d;
    logic [3:0][1:0]  rank_q,       rank_d;
    logic [3:0]       voice_trig_q, voice_trig_d;
    logic             drop_q,       drop_d;

    logic [7:0] press;
    logic [7:0] release_ev;
    logic [7:0] svc_press;
    logic [7:0] svc_rel;
    logic       rel_hit;
    logic [2:0] rel_idx;
    logic       press_hit;
    logic [2:0] press_idx;
    logic       free_hit;
    logic [1:0] free_v;
    logic [1:0] oldest_v;
    logic       match_hit;
    logic [1:0] match_v;
    logic       do_alloc;
    logic [1:0] tgt;

    always_comb begin
        press      = bus.note & ~note_q;
        release_ev = ~bus.note & note_q;

        state_d      = IDLE;
        note_d       = bus.note;
        voice_on_d   = voice_on_q;
        voice_note_d = voice_note_q;
        rank_d       = rank_q;
        voice_trig_d = 4'b0000;
        drop_d       = 1'b0;
        svc_press    = 8'h00;
        svc_rel      = 8'h00;
        do_alloc     = 1'b0;
        tgt          = 2'd0;

        // Lowest-index pending events (scan downwards so the lowest wins).
        rel_hit   = 1'b0;
        rel_idx   = 3'd0;
        press_hit = 1'b0;
        press_idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (pend_rel_q[i]) begin
                rel_hit = 1'b1;
                rel_idx = 3'(i);
            end
            if (pend_press_q[i]) begin
                press_hit = 1'b1;
                press_idx = 3'(i);
            end
        end

        free_hit = 1'b0;
        free_v   = 2'd0;
        for (int v = 3; v >= 0; v--) begin
            if (!voice_on_q[v]) begin
                free_hit = 1'b1;
                free_v   = 2'(v);
            end
        end

        oldest_v  = 2'd0;
        match_hit = 1'b0;
        match_v   = 2'd0;
        for (int v = 0; v < 4; v++) begin
            if (rank_q[v] == 2'd3) begin
                oldest_v = 2'(v);
            end
            if (voice_on_q[v] && (voice_note_q[v] == rel_idx)) begin
                match_hit = 1'b1;
                match_v   = 2'(v);
            end
        end

        if (rel_hit) begin
            // A release whose voice was stolen has nothing left to silence.
            state_d          = REL;
            svc_rel[rel_idx] = 1'b1;
            if (match_hit) begin
                voice_on_d[match_v] = 1'b0;
            end
        end else if (press_hit) begin
            svc_press[press_idx] = 1'b1;
            if (free_hit) begin
                state_d  = ALLOC;
                do_alloc = 1'b1;
                tgt      = free_v;
            end else if (STEAL_EN) begin
                state_d  = STEAL;
                do_alloc = 1'b1;
                tgt      = oldest_v;
            end else begin
                drop_d   = 1'b1;
            end
        end

        if (do_alloc) begin
            voice_on_d[tgt]   = 1'b1;
            voice_note_d[tgt] = press_idx;
            voice_trig_d[tgt] = 1'b1;
            // Move the allocated voice to the front; the voices that were
            // younger than it each age by one, keeping ranks a permutation.
            for (int v = 0; v < 4; v++) begin
                if (2'(v) == tgt) begin
                    rank_d[v] = 2'd0;
                end else if (rank_q[v] < rank_q[tgt]) begin
                    rank_d[v] = rank_q[v] + 2'd1;
                end
            end
        end

        // A release landing on a still-queued press cancels that press; a
        // press landing on a queued release keeps both so the release runs
        // first and the press retriggers afterwards.
        pend_press_d = (pend_press_q & ~svc_press & ~release_ev) | press;
        pend_rel_d   = (pend_rel_q & ~svc_rel) | release_ev;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            note_q       <= 8'h00;
            pend_press_q <= 8'h00;
            pend_rel_q   <= 8'h00;
            voice_on_q   <= 4'b0000;
            voice_note_q <= '0;
            rank_q       <= RANK_RST;
            voice_trig_q <= 4'b0000;
            drop_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            note_q       <= note_d;
            pend_press_q <= pend_press_d;
            pend_rel_q   <= pend_rel_d;
            voice_on_q   <= voice_on_d;
            voice_note_q <= voice_note_d;
            rank_q       <= rank_d;
            voice_trig_q <= voice_trig_d;
            drop_q       <= drop_d;
        end
    end

    assign bus.voice_on   = voice_on_q;
    assign bus.voice_note = voice_note_q;
    assign bus.voice_trig = voice_trig_q;
    assign bus.steal      = (state_q == STEAL);
    assign bus.drop       = drop_q;
    assign bus.busy       = (|pend_press_q) | (|pend_rel_q);

endmodule
`default_nettype wire

// File: tb/tb_voice_allocator.sv
`default_nettype none
// ============================================================================
//  Module      : tb_voice_allocator
//  Description : Directed bench for voice_allocator. Two instances share clock,
//                reset and key stimulus: one with stealing enabled, one with
//                dropping. Expected values are hand-computed constants.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_voice_allocator;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    voice_allocator_if bus_s ();
    voice_allocator_if bus_d ();

    voice_allocator #(.STEAL_EN(1'b1)) u_dut_steal (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_s.slave)
    );

    voice_allocator #(.STEAL_EN(1'b0)) u_dut_drop (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_d.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs,
                            input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_note(input logic [7:0] val);
        bus_s.note = val;
        bus_d.note = val;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        set_note(8'h00);
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        set_note(8'h00);
        tick();
        tick();

        // Reset state
        check_eq("rst_voice_on",   bus_s.voice_on,   32'h0);
        check_eq("rst_voice_note", bus_s.voice_note, 32'h0);
        check_eq("rst_trig",       bus_s.voice_trig, 32'h0);
        check_eq("rst_steal",      bus_s.steal,      32'h0);
        check_eq("rst_drop",       bus_d.drop,       32'h0);
        check_eq("rst_busy",       bus_s.busy,       32'h0);
        rst_n = 1'b1;

        // Single press of note 2, then release
        set_note(8'h04);
        tick();
        check_eq("p2_busy",      bus_s.busy,             32'h1);
        check_eq("p2_on_early",  bus_s.voice_on,         32'h0);
        tick();
        check_eq("p2_on",        bus_s.voice_on,         32'h1);
        check_eq("p2_note",      bus_s.voice_note[2:0],  32'h2);
        check_eq("p2_trig",      bus_s.voice_trig,       32'h1);
        check_eq("p2_busy_done", bus_s.busy,             32'h0);
        tick();
        check_eq("p2_trig_once", bus_s.voice_trig,       32'h0);
        set_note(8'h00);
        tick();
        tick();
        check_eq("r2_on",        bus_s.voice_on,         32'h0);

        // Four-note burst
        do_reset();
        set_note(8'h0F);
        tick();
        check_eq("burst_busy0", bus_s.busy, 32'h1);
        for (int i = 0; i < 4; i++) begin
            tick();
            check_eq($sformatf("burst_on%0d", i),   bus_s.voice_on,
                     32'((1 << (i + 1)) - 1));
            check_eq($sformatf("burst_trig%0d", i), bus_s.voice_trig,
                     32'(1 << i));
            check_eq($sformatf("burst_busy%0d", i + 1), bus_s.busy,
                     (i < 3) ? 32'h1 : 32'h0);
        end
        check_eq("burst_notes", bus_s.voice_note, 32'h688);

        // Five sequential presses: steal vs drop
        do_reset();
        set_note(8'h01); tick(); tick();
        set_note(8'h03); tick(); tick();
        set_note(8'h07); tick(); tick();
        set_note(8'h0F); tick(); tick();
        check_eq("seq4_on_s",    bus_s.voice_on,   32'hF);
        check_eq("seq4_notes_d", bus_d.voice_note, 32'h688);
        set_note(8'h1F);
        tick();
        tick();
        check_eq("steal_notes", bus_s.voice_note, 32'h68C);
        check_eq("steal_trig",  bus_s.voice_trig, 32'h1);
        check_eq("steal_pulse", bus_s.steal,      32'h1);
        check_eq("steal_nodrp", bus_s.drop,       32'h0);
        check_eq("drop_pulse",  bus_d.drop,       32'h1);
        check_eq("drop_nostl",  bus_d.steal,      32'h0);
        check_eq("drop_notes",  bus_d.voice_note, 32'h688);
        check_eq("drop_trig",   bus_d.voice_trig, 32'h0);
        tick();
        check_eq("steal_once",  bus_s.steal,      32'h0);
        check_eq("drop_once",   bus_d.drop,       32'h0);
        set_note(8'h1E);
        tick();
        tick();
        check_eq("rel0_s_on",    bus_s.voice_on,   32'hF);
        check_eq("rel0_s_notes", bus_s.voice_note, 32'h68C);
        check_eq("rel0_d_on",    bus_d.voice_on,   32'hE);

        // Simultaneous release of note 1 and press of note 5
        do_reset();
        set_note(8'h0F);
        repeat (5) tick();
        check_eq("full_on", bus_s.voice_on, 32'hF);
        set_note(8'h2D);
        tick();
        tick();
        check_eq("swap_rel_on",   bus_s.voice_on,   32'hD);
        check_eq("swap_rel_trig", bus_s.voice_trig, 32'h0);
        check_eq("swap_rel_busy", bus_s.busy,       32'h1);
        tick();
        check_eq("swap_on",       bus_s.voice_on,   32'hF);
        check_eq("swap_notes",    bus_s.voice_note, 32'h6A8);
        check_eq("swap_trig",     bus_s.voice_trig, 32'h2);
        check_eq("swap_notes_d",  bus_d.voice_note, 32'h6A8);

        // Reset in the middle of a burst
        do_reset();
        set_note(8'h0F);
        tick();
        tick();
        check_eq("mid_on_pre", bus_s.voice_on, 32'h1);
        rst_n = 1'b0;
        #1;
        check_eq("mid_on_rst",    bus_s.voice_on,   32'h0);
        check_eq("mid_note_rst",  bus_s.voice_note, 32'h0);
        check_eq("mid_trig_rst",  bus_s.voice_trig, 32'h0);
        check_eq("mid_busy_rst",  bus_s.busy,       32'h0);
        tick();
        rst_n = 1'b1;
        tick();
        check_eq("mid_busy_after", bus_s.busy, 32'h1);
        tick();
        check_eq("mid_first_on",   bus_s.voice_on,   32'h1);
        check_eq("mid_first_trig", bus_s.voice_trig, 32'h1);
        tick();
        tick();
        tick();
        check_eq("mid_all_on",    bus_s.voice_on,   32'hF);
        check_eq("mid_all_notes", bus_s.voice_note, 32'h688);
        check_eq("mid_idle",      bus_s.busy,       32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/voice_allocator.md
VOICE_ALLOCATOR -- requirements
Module: voice_allocator

Interface
REQ-001 Parameter: STEAL_EN, default 1, 1 = steal least-recently-allocated voice when all busy; 0 = drop press.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 note  input  8  held-note mask from key decode; bit i = note i (do..do') held.
REQ-005 voice_on  output  4  bit v = voice v currently sounding.
REQ-006 voice_note  output  12  note index (0..7) of voice v in bits [3v+2:3v].
REQ-007 voice_trig  output  4  one-cycle pulse on voice v when assigned a note (envelope restart).
REQ-008 steal  output  1  one-cycle pulse when an allocation took a busy voice.
REQ-009 drop  output  1  one-cycle pulse when a press was discarded (STEAL_EN=0, all voices busy).
REQ-010 busy  output  1  high while any press or release event is pending.

Function
REQ-011 Edge detect: note_q registers note each cycle; press = note & ~note_q, release = ~note & note_q.
REQ-012 Pending: pend_press |= press, pend_rel |= release each cycle, and the serviced bit is cleared in the same cycle.
REQ-013 Release arriving for a bit with pend_press set clears that pend_press bit; no allocation occurs.
REQ-014 Press arriving for a bit with pend_rel set keeps both; release is serviced first, then press (retrigger).
REQ-015 Exactly one event serviced per cycle; state register values IDLE, REL, ALLOC, STEAL name the action taken at that edge.
REQ-016 Priority: any pend_rel before any pend_press; within a class, lowest note index first.
REQ-017 REL: voice with voice_on=1 and voice_note = index is cleared to off; none matching (stolen earlier) -> bit cleared, no voice change.
REQ-018 ALLOC: lowest-numbered free voice takes note index, voice_on set, voice_trig pulses for that voice.
REQ-019 STEAL (no free voice, STEAL_EN=1): voice with age 3 is reassigned, voice_trig and steal pulse.
REQ-020 No free voice, STEAL_EN=0: press bit cleared, drop pulses, voices unchanged.
REQ-021 Age: 2-bit rank per voice, permutation of 0..3 at all times; on allocate/steal of voice v with old rank r, v -> 0, every voice with rank < r increments; release does not change ranks.
REQ-022 Latency: note change sampled at edge k sets pend at edge k; sole event updates voice outputs at edge k+1.
REQ-023 busy = |pend_press | |pend_rel, registered-state derived, no combinational path from note.
REQ-024 Same note never occupies two voices simultaneously.

Reset
REQ-025 rst_n low: voice_on=0, voice_note=0, voice_trig=0, steal=0, drop=0, busy=0, note_q=0, pend=0, state=IDLE, ranks voice v = v.
REQ-026 Reset mid-service discards all pending events; after release, currently held notes appear as presses (note_q=0).

Verification
REQ-027 Press note 2 alone -> one cycle later voice_on=0001, voice_note[2:0]=2, voice_trig=0001; release -> voice_on=0000 next cycle.
REQ-028 note 00000000 -> 00001111 in one cycle -> voices 0..3 get notes 0,1,2,3 on four consecutive cycles, busy high for 4 cycles.
REQ-029 Five notes pressed sequentially, STEAL_EN=1 -> fifth press steals voice holding first note, steal pulse; later release of first note changes nothing.
REQ-030 Same with STEAL_EN=0 -> drop pulses, voices keep notes 0..3.
REQ-031 Simultaneous release of note 1 and press of note 5 -> release serviced first cycle, note 5 allocated into freed voice next cycle.
REQ-032 Assert rst_n low during a 4-note burst -> all outputs zero immediately; after release, held notes re-allocated from voice 0.
